// File: rtl/chaos_rbuf.sv
// Chaos receive buffer: captures one link packet (up to 256 words) into RAM,
// checks the trailing checksum word, then holds the packet for host read-out.
module chaos_rbuf (
    input  logic        clk,
    input  logic        reset,
    input  logic        ren,
    input  logic        rx_stb,
    input  logic [15:0] rx_data,
    input  logic        rx_eop,
    input  logic        rrp,
    output logic [15:0] rdata,
    output logic [8:0]  rbct,
    output logic        rdone,
    output logic        rbusy,
    output logic        rcrcerr,
    output logic        rovf,
    output logic        rlost
);

    typedef enum logic [2:0] {S_IDLE, S_LISTEN, S_RECV, S_DROP, S_DONE} state_t;

    localparam logic [8:0] FULL = 9'd256;

    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

    logic [15:0] ram [256];

    state_t      state_q, state_d;
    logic [7:0]  wptr_q, wptr_d;
    logic [7:0]  rptr_q, rptr_d;
    logic [8:0]  rbct_q, rbct_d;
    logic [15:0] sum_q, sum_d;
    logic        crc_q, crc_d;
    logic        ovf_q, ovf_d;
    logic        lost_q, lost_d;
    logic        done_q, busy_q;
    logic [15:0] rdata_q;
    logic [15:0] sum_next;
    logic        ram_we;
    logic        rd_en;

    assign sum_next = csum_add(sum_q, rx_data);

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        rbct_d  = rbct_q;
        sum_d   = sum_q;
        crc_d   = crc_q;
        ovf_d   = ovf_q;
        lost_d  = lost_q;
        ram_we  = 1'b0;
        rd_en   = 1'b0;
        // Arming wins over everything, including a word arriving in the same cycle.
        if (ren) begin
            state_d = S_LISTEN;
            wptr_d  = 8'd0;
            rptr_d  = 8'd0;
            rbct_d  = 9'd0;
            sum_d   = 16'd0;
            crc_d   = 1'b0;
            ovf_d   = 1'b0;
            lost_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_stb) lost_d = 1'b1;
                end
                S_LISTEN, S_RECV: begin
                    if (rx_stb) begin
                        if (rbct_q == FULL) begin
                            ovf_d   = 1'b1;
                            crc_d   = 1'b0;
                            state_d = rx_eop ? S_DONE : S_DROP;
                        end else begin
                            ram_we  = !reset;
                            wptr_d  = wptr_q + 8'd1;
                            rbct_d  = rbct_q + 9'd1;
                            sum_d   = sum_next;
                            state_d = S_RECV;
                            if (rx_eop) begin
                                crc_d   = (sum_next != 16'd0);
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (rx_stb && rx_eop) begin
                        crc_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (rx_stb) lost_d = 1'b1;
                    if (rrp) begin
                        rd_en  = 1'b1;
                        rptr_d = rptr_q + 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wptr_q  <= 8'd0;
            rptr_q  <= 8'd0;
            rbct_q  <= 9'd0;
            sum_q   <= 16'd0;
            crc_q   <= 1'b0;
            ovf_q   <= 1'b0;
            lost_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rbct_q  <= rbct_d;
            sum_q   <= sum_d;
            crc_q   <= crc_d;
            ovf_q   <= ovf_d;
            lost_q  <= lost_d;
            done_q  <= (state_d == S_DONE);
            busy_q  <= (state_d == S_RECV) || (state_d == S_DROP);
        end
    end

    // RAM has no reset; contents survive reset and arming.
    always_ff @(posedge clk) begin
        if (ram_we) ram[wptr_q] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) rdata_q <= 16'd0;
        else if (rd_en) rdata_q <= ram[rptr_q];
    end

    assign rdata   = rdata_q;
    assign rbct    = rbct_q;
    assign rdone   = done_q;
    assign rbusy   = busy_q;
    assign rcrcerr = crc_q;
    assign rovf    = ovf_q;
    assign rlost   = lost_q;

endmodule

// File: tb/tb_chaos_rbuf.sv
// Directed bench for chaos_rbuf: a table of single-cycle vectors plus
// hand-written sequences for full, overflow and reset-mid-packet cases.
module tb_chaos_rbuf;

    logic        clk = 1'b0;
    logic        reset, ren, rx_stb, rx_eop, rrp;
    logic [15:0] rx_data;
    logic [15:0] rdata;
    logic [8:0]  rbct;
    logic        rdone, rbusy, rcrcerr, rovf, rlost;

    int n_cmp  = 0;
    int n_fail = 0;

    chaos_rbuf dut (
        .clk(clk), .reset(reset), .ren(ren), .rx_stb(rx_stb), .rx_data(rx_data),
        .rx_eop(rx_eop), .rrp(rrp), .rdata(rdata), .rbct(rbct), .rdone(rdone),
        .rbusy(rbusy), .rcrcerr(rcrcerr), .rovf(rovf), .rlost(rlost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic        stb;
        logic [15:0] data;
        logic        eop;
        logic        rrp;
        logic [15:0] x_rdata;
        logic [8:0]  x_rbct;
        logic        x_done;
        logic        x_busy;
        logic        x_crc;
        logic        x_ovf;
        logic        x_lost;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] xd, input logic [8:0] xb,
                             input logic xdone, input logic xbusy, input logic xcrc,
                             input logic xovf, input logic xlost);
        check({tag, ".rdata"},   32'(rdata),   32'(xd));
        check({tag, ".rbct"},    32'(rbct),    32'(xb));
        check({tag, ".rdone"},   32'(rdone),   32'(xdone));
        check({tag, ".rbusy"},   32'(rbusy),   32'(xbusy));
        check({tag, ".rcrcerr"}, 32'(rcrcerr), 32'(xcrc));
        check({tag, ".rovf"},    32'(rovf),    32'(xovf));
        check({tag, ".rlost"},   32'(rlost),   32'(xlost));
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic r, input logic s, input logic [15:0] d, input logic e, input logic p);
        ren = r; rx_stb = s; rx_data = d; rx_eop = e; rrp = p;
        @(posedge clk);
        #1;
        ren = 1'b0; rx_stb = 1'b0; rx_eop = 1'b0; rrp = 1'b0; rx_data = 16'h0;
    endtask

    task automatic add(input logic r, input logic s, input logic [15:0] d, input logic e, input logic p,
                       input logic [15:0] xd, input logic [8:0] xb, input logic xdone, input logic xbusy,
                       input logic xcrc, input logic xovf, input logic xlost);
        vec_t v;
        v = '{r, s, d, e, p, xd, xb, xdone, xbusy, xcrc, xovf, xlost};
        vecs.push_back(v);
    endtask

    logic [15:0] model [256];
    logic [15:0] last;

    initial begin
        //   ren stb data     eop rrp  rdata    rbct  done busy crc ovf lost
        add(0, 1, 16'hAAAA, 0, 0, 16'h0000, 9'd0, 0, 0, 0, 0, 1);  // word while idle
        add(1, 1, 16'hBBBB, 0, 0, 16'h0000, 9'd0, 0, 0, 0, 0, 0);  // ren beats stb
        add(0, 1, 16'h0001, 0, 0, 16'h0000, 9'd1, 0, 1, 0, 0, 0);
        add(0, 1, 16'h0002, 0, 0, 16'h0000, 9'd2, 0, 1, 0, 0, 0);
        add(0, 1, 16'hFFFD, 1, 0, 16'h0000, 9'd3, 1, 0, 0, 0, 0);
        add(0, 0, 16'h0000, 0, 1, 16'h0001, 9'd3, 1, 0, 0, 0, 0);
        add(0, 0, 16'h0000, 0, 1, 16'h0002, 9'd3, 1, 0, 0, 0, 0);
        add(0, 0, 16'h0000, 0, 1, 16'hFFFD, 9'd3, 1, 0, 0, 0, 0);
        add(0, 1, 16'h5555, 0, 0, 16'hFFFD, 9'd3, 1, 0, 0, 0, 1);  // word while done
        add(1, 0, 16'h0000, 0, 0, 16'hFFFD, 9'd0, 0, 0, 0, 0, 0);
        add(0, 0, 16'h0000, 0, 1, 16'hFFFD, 9'd0, 0, 0, 0, 0, 0);  // rrp ignored in listen
        add(0, 1, 16'h0001, 0, 0, 16'hFFFD, 9'd1, 0, 1, 0, 0, 0);
        add(0, 1, 16'h0002, 0, 0, 16'hFFFD, 9'd2, 0, 1, 0, 0, 0);
        add(0, 1, 16'hFFFE, 1, 0, 16'hFFFD, 9'd3, 1, 0, 1, 0, 0);  // bad checksum
        add(0, 0, 16'h0000, 0, 1, 16'h0001, 9'd3, 1, 0, 1, 0, 0);
        add(1, 0, 16'h0000, 0, 0, 16'h0001, 9'd0, 0, 0, 0, 0, 0);
        add(0, 1, 16'h1111, 0, 0, 16'h0001, 9'd1, 0, 1, 0, 0, 0);
        add(0, 1, 16'h2222, 0, 0, 16'h0001, 9'd2, 0, 1, 0, 0, 0);
        add(0, 1, 16'h3333, 0, 0, 16'h0001, 9'd3, 0, 1, 0, 0, 0);
        add(0, 1, 16'h4444, 0, 0, 16'h0001, 9'd4, 0, 1, 0, 0, 0);
        add(0, 1, 16'h5555, 0, 0, 16'h0001, 9'd5, 0, 1, 0, 0, 0);
        add(1, 0, 16'h0000, 0, 0, 16'h0001, 9'd0, 0, 0, 0, 0, 0);  // abandon packet
        add(0, 1, 16'h1234, 0, 0, 16'h0001, 9'd1, 0, 1, 0, 0, 0);
        add(0, 1, 16'hEDCC, 1, 0, 16'h0001, 9'd2, 1, 0, 0, 0, 0);
        add(0, 0, 16'h0000, 0, 1, 16'h1234, 9'd2, 1, 0, 0, 0, 0);
        add(1, 0, 16'h0000, 0, 0, 16'h1234, 9'd0, 0, 0, 0, 0, 0);
        add(0, 1, 16'h0000, 1, 0, 16'h1234, 9'd1, 1, 0, 0, 0, 0);  // single zero word passes
        add(0, 0, 16'h0000, 0, 1, 16'h0000, 9'd1, 1, 0, 0, 0, 0);
        add(1, 0, 16'h0000, 0, 0, 16'h0000, 9'd0, 0, 0, 0, 0, 0);
        add(0, 1, 16'h0007, 1, 0, 16'h0000, 9'd1, 1, 0, 1, 0, 0);  // single nonzero word fails

        reset = 1'b1; ren = 0; rx_stb = 0; rx_data = 0; rx_eop = 0; rrp = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        check_all("reset", 16'h0, 9'd0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].ren, vecs[i].stb, vecs[i].data, vecs[i].eop, vecs[i].rrp);
            check_all($sformatf("vec%0d", i), vecs[i].x_rdata, vecs[i].x_rbct, vecs[i].x_done,
                      vecs[i].x_busy, vecs[i].x_crc, vecs[i].x_ovf, vecs[i].x_lost);
        end

        // Exactly 256 words, checksum in the last slot.
        cyc(1, 0, 16'h0, 0, 0);
        for (int i = 0; i < 255; i++) begin
            model[i] = 16'(i + 1);
            cyc(0, 1, model[i], 0, 0);
        end
        model[255] = 16'h8080;
        cyc(0, 1, model[255], 1, 0);
        check_all("full256", 16'h0007 == 16'h0 ? 16'h0 : rdata, 9'd256, 1, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            cyc(0, 0, 16'h0, 0, 1);
            check($sformatf("full256.rd%0d", i), 32'(rdata), 32'(model[i]));
        end

        // 300 words: 257th starts dropping, eop on the 300th.
        cyc(1, 0, 16'h0, 0, 0);
        for (int i = 0; i < 299; i++) begin
            if (i < 256) model[i] = 16'hA000 + 16'(i);
            cyc(0, 1, 16'hA000 + 16'(i), 0, 0);
            if (i == 256) begin
                check("ovf.busy257", 32'(rbusy), 32'd1);
                check("ovf.rbct257", 32'(rbct), 32'd256);
            end
        end
        cyc(0, 1, 16'hA000 + 16'd299, 1, 0);
        last = rdata;
        check_all("ovf300", last, 9'd256, 1, 0, 0, 1, 0);
        for (int i = 0; i < 256; i++) begin
            cyc(0, 0, 16'h0, 0, 1);
            check($sformatf("ovf300.rd%0d", i), 32'(rdata), 32'(model[i]));
        end
        cyc(0, 0, 16'h0, 0, 1);
        check("ovf300.rdwrap", 32'(rdata), 32'(model[0]));

        // Reset in the middle of a packet.
        cyc(1, 0, 16'h0, 0, 0);
        cyc(0, 1, 16'h0101, 0, 0);
        cyc(0, 1, 16'h0202, 0, 0);
        check("midrst.busy", 32'(rbusy), 32'd1);
        reset = 1'b1;
        cyc(0, 0, 16'h0, 0, 0);
        reset = 1'b0;
        check_all("midrst", 16'h0, 9'd0, 0, 0, 0, 0, 0);
        cyc(0, 0, 16'h0, 0, 1);
        check_all("midrst.rrp", 16'h0, 9'd0, 0, 0, 0, 0, 0);
        cyc(1, 0, 16'h0, 0, 0);
        cyc(0, 1, 16'h1234, 0, 0);
        cyc(0, 1, 16'hEDCC, 1, 0);
        cyc(0, 0, 16'h0, 0, 1);
        check_all("midrst.after", 16'h1234, 9'd2, 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
